// File: rtl/snd_tone_gen.sv
// snd_tone_gen: multi-channel square-wave tone generator with a registered mix level.
// Define SND_ENVELOPE_EN to add the per-note duration envelope and snd_duration port.
module snd_tone_gen #(
  parameter int NUM_CHANNELS = 4,
  parameter int COUNT_WIDTH  = 26,
  parameter int TICK_DIVIDER = 50000,
  parameter int DUR_WIDTH    = 12,
  localparam int SEL_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int MIX_W = $clog2(NUM_CHANNELS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_async,
  input  logic [SEL_W-1:0]        snd_channel_sel,
  input  logic [COUNT_WIDTH-1:0]  snd_max_count,
  input  logic                    snd_latch_max_count,
`ifdef SND_ENVELOPE_EN
  input  logic [DUR_WIDTH-1:0]    snd_duration,
`endif
  output logic [NUM_CHANNELS-1:0] snd_wave,
  output logic [NUM_CHANNELS-1:0] snd_active,
  output logic [MIX_W-1:0]        snd_mix
);

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16 || COUNT_WIDTH < 1 ||
      TICK_DIVIDER < 1 || DUR_WIDTH < 1) begin : g_cfg_check
    $error("snd_tone_gen: unsupported parameter set");
  end

  function automatic logic [MIX_W-1:0] popcount(input logic [NUM_CHANNELS-1:0] v);
    logic [MIX_W-1:0] n;
    n = {MIX_W{1'b0}};
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      n = n + MIX_W'(v[i]);
    end
    return n;
  endfunction

  logic [COUNT_WIDTH-1:0]  period_r   [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0]  period_nxt [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0]  count_r    [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0]  count_nxt  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] wave_r;
  logic [NUM_CHANNELS-1:0] wave_nxt;
  logic [NUM_CHANNELS-1:0] latch_hit_s;
  logic [NUM_CHANNELS-1:0] expire_s;
  logic [MIX_W-1:0]        mix_r;

  // An out-of-range select matches no channel, so the latch is silently dropped.
  always_comb begin
    latch_hit_s = {NUM_CHANNELS{1'b0}};
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (snd_latch_max_count && (snd_channel_sel == SEL_W'(i))) begin
        latch_hit_s[i] = 1'b1;
      end else begin
        latch_hit_s[i] = 1'b0;
      end
    end
  end

`ifdef SND_ENVELOPE_EN
  localparam int TICK_W = (TICK_DIVIDER > 1) ? $clog2(TICK_DIVIDER) : 1;

  logic [TICK_W-1:0]    presc_r;
  logic                 tick_s;
  logic [DUR_WIDTH-1:0] dur_r   [NUM_CHANNELS];
  logic [DUR_WIDTH-1:0] dur_nxt [NUM_CHANNELS];

  assign tick_s = (presc_r == TICK_W'(TICK_DIVIDER - 1));

  // Free-running envelope prescaler; tick_s marks its terminal count.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      presc_r <= {TICK_W{1'b0}};
    end else if (tick_s) begin
      presc_r <= {TICK_W{1'b0}};
    end else begin
      presc_r <= presc_r + TICK_W'(1);
    end
  end

  // Duration countdown: a latch on the tick edge reloads instead of counting.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      dur_nxt[i]  = dur_r[i];
      expire_s[i] = 1'b0;
      if (latch_hit_s[i]) begin
        dur_nxt[i] = snd_duration;
      end else if (tick_s && (dur_r[i] == DUR_WIDTH'(1))) begin
        dur_nxt[i]  = {DUR_WIDTH{1'b0}};
        expire_s[i] = 1'b1;
      end else if (tick_s && (dur_r[i] > DUR_WIDTH'(1))) begin
        dur_nxt[i] = dur_r[i] - DUR_WIDTH'(1);
      end else begin
        dur_nxt[i] = dur_r[i];
      end
    end
  end

  // Duration registers.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        dur_r[i] <= {DUR_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        dur_r[i] <= dur_nxt[i];
      end
    end
  end
`else
  assign expire_s = {NUM_CHANNELS{1'b0}};
`endif

  // Per-channel tone state: latch restarts phase, expiry silences, else count/toggle.
  always_comb begin
    wave_nxt = wave_r;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      period_nxt[i] = period_r[i];
      count_nxt[i]  = count_r[i];
      if (latch_hit_s[i]) begin
        period_nxt[i] = snd_max_count;
        count_nxt[i]  = {COUNT_WIDTH{1'b0}};
        wave_nxt[i]   = 1'b0;
      end else if (expire_s[i]) begin
        period_nxt[i] = {COUNT_WIDTH{1'b0}};
        count_nxt[i]  = {COUNT_WIDTH{1'b0}};
        wave_nxt[i]   = 1'b0;
      end else if (period_r[i] == {COUNT_WIDTH{1'b0}}) begin
        count_nxt[i] = {COUNT_WIDTH{1'b0}};
        wave_nxt[i]  = 1'b0;
      end else if (count_r[i] == (period_r[i] - COUNT_WIDTH'(1))) begin
        count_nxt[i] = {COUNT_WIDTH{1'b0}};
        wave_nxt[i]  = ~wave_r[i];
      end else begin
        count_nxt[i] = count_r[i] + COUNT_WIDTH'(1);
      end
    end
  end

  // Tone registers and the mix level, which trails the waves by one cycle.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        period_r[i] <= {COUNT_WIDTH{1'b0}};
        count_r[i]  <= {COUNT_WIDTH{1'b0}};
      end
      wave_r <= {NUM_CHANNELS{1'b0}};
      mix_r  <= {MIX_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        period_r[i] <= period_nxt[i];
        count_r[i]  <= count_nxt[i];
      end
      wave_r <= wave_nxt;
      mix_r  <= popcount(wave_r);
    end
  end

  // A channel is active whenever its period register is nonzero.
  always_comb begin
    snd_active = {NUM_CHANNELS{1'b0}};
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      snd_active[i] = (period_r[i] != {COUNT_WIDTH{1'b0}});
    end
  end

  assign snd_wave = wave_r;
  assign snd_mix  = mix_r;

endmodule

// File: tb/tb_snd_tone_gen.sv
// Scoreboard bench for snd_tone_gen: a phase-arithmetic reference model pushes the
// expected outputs per edge; a monitor pops and compares after each rising edge.
module tb_snd_tone_gen;
  localparam int NCH   = 3;
  localparam int CW    = 26;
  localparam int TD    = 10;
  localparam int DW    = 12;
  localparam int SEL_W = 2;
  localparam int MIX_W = 2;
`ifdef SND_ENVELOPE_EN
  localparam bit ENV = 1'b1;
`else
  localparam bit ENV = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_async;
  logic [SEL_W-1:0] sel;
  logic [CW-1:0]    max_count;
  logic             latch;
`ifdef SND_ENVELOPE_EN
  logic [DW-1:0]    dur;
`endif
  logic [NCH-1:0]   wave;
  logic [NCH-1:0]   active;
  logic [MIX_W-1:0] mix;

  always #5 clk = ~clk;

  snd_tone_gen #(
    .NUM_CHANNELS(NCH), .COUNT_WIDTH(CW), .TICK_DIVIDER(TD), .DUR_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst_async(rst_async),
    .snd_channel_sel(sel),
    .snd_max_count(max_count),
    .snd_latch_max_count(latch),
`ifdef SND_ENVELOPE_EN
    .snd_duration(dur),
`endif
    .snd_wave(wave),
    .snd_active(active),
    .snd_mix(mix)
  );

  typedef struct {
    logic [NCH-1:0]   wave;
    logic [NCH-1:0]   active;
    logic [MIX_W-1:0] mix;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Reference model: rising edges since reset, per-channel period, latch edge, expiry edge.
  int             edge_n;
  int             per    [NCH];
  int             t0     [NCH];
  int             expiry [NCH];
  logic [NCH-1:0] prev_wave;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at edge %0d", name, act, req, edge_n);
    end
  endtask

  task automatic model_reset();
    edge_n    = 0;
    prev_wave = '0;
    for (int i = 0; i < NCH; i++) begin
      per[i] = 0; t0[i] = 0; expiry[i] = 0;
    end
  endtask

  // Called at a falling edge: drive inputs, predict the state after the next rising edge.
  task automatic step(input bit l, input int s, input int p, input int d);
    exp_t e;
    latch     = l;
    sel       = SEL_W'(s);
    max_count = CW'(p);
`ifdef SND_ENVELOPE_EN
    dur       = DW'(d);
`endif
    edge_n++;
    for (int i = 0; i < NCH; i++) begin
      if (l && s == i) begin
        per[i]    = p;
        t0[i]     = edge_n;
        expiry[i] = (ENV && d > 0) ? ((edge_n / TD) + 1) * TD + (d - 1) * TD : 0;
      end else if (expiry[i] != 0 && expiry[i] == edge_n) begin
        per[i]    = 0;
        expiry[i] = 0;
      end
      e.active[i] = (per[i] != 0);
      e.wave[i]   = (per[i] != 0) && ((((edge_n - t0[i]) / per[i]) % 2) == 1);
    end
    e.mix     = MIX_W'($countones(prev_wave));
    prev_wave = e.wave;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 0);
  endtask

  // Monitor: outputs are presented every cycle; compare away from the rising edge.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("snd_wave",   32'(wave),   32'(mon_e.wave));
      chk("snd_active", 32'(active), 32'(mon_e.active));
      chk("snd_mix",    32'(mix),    32'(mon_e.mix));
    end
  end

  initial begin
    rst_async = 1'b1;
    latch     = 1'b0;
    sel       = '0;
    max_count = '0;
`ifdef SND_ENVELOPE_EN
    dur       = '0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    rst_async = 1'b0;

    idle(20);
    step(1'b1, 0, 3, 0); idle(12);
    step(1'b1, 1, 5, 0); idle(30);
    step(1'b1, 2, 4, 0); idle(9);
    step(1'b1, 2, 0, 0); idle(3);
    step(1'b1, 3, 7, 0); idle(5);
    idle(1); step(1'b1, 0, 4, 0); idle(10);
    repeat (4) step(1'b1, 1, 2, 0);
    idle(6);
    if (ENV) begin
      step(1'b1, 1, 2, 2); idle(40);
      step(1'b1, 1, 2, 0); idle(100);
    end
    repeat (300) begin
      if ($urandom_range(3) == 0) begin
        step(1'b1, int'($urandom_range(3)), int'($urandom_range(9)), int'($urandom_range(3)));
      end else begin
        step(1'b0, 0, 0, 0);
      end
    end

    // Asynchronous reset while tones play: outputs clear without a clock edge.
    step(1'b1, 0, 2, 0); step(1'b1, 1, 3, 0); idle(5);
    #1 rst_async = 1'b1;
    #1;
    chk("reset_wave",   32'(wave),   32'd0);
    chk("reset_active", 32'(active), 32'd0);
    chk("reset_mix",    32'(mix),    32'd0);
    @(negedge clk);
    rst_async = 1'b0;
    model_reset();
    idle(5);
    step(1'b1, 2, 1, 0); idle(10);

    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
